qtcore_scan_ctrl: RTL and testbench

//  Sequencer for the qtcore scan chain and processor enable. Converts byte-wide host

---
 rtl/qtcore_scan_ctrl_pkg.sv | 35 +++
 rtl/qtcore_scan_ctrl_shifter.sv | 35 +++
 rtl/qtcore_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_qtcore_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/qtcore_scan_ctrl_pkg.sv
// Shared opcodes, state encoding and CRC helper for the qtcore scan sequencer.
// The CRC helper is only referenced when QTCORE_SCAN_CRC_EN is defined.
package qtcore_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_XCHG  = 2'd0,
    OP_RUN   = 2'd1,
    OP_RESET = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DRAIN,
    S_RUN,
    S_RST
  } state_e;

  localparam int CHAIN_BITS_DEF     = 176;
  localparam int MIN_RUN_CYCLES_DEF = 4;
  localparam int RST_CYCLES_DEF     = 2;
  localparam logic [7:0] CRC_POLY   = 8'h07;

  // CRC-8, MSB first, one whole byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/qtcore_scan_ctrl_shifter.sv
// 8-bit parallel-load / serial-exchange register with bit counter.
// MSB leaves first; the incoming serial bit enters at the LSB.
module qtcore_scan_ctrl_shifter (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_en_i,
  input  logic       ser_i,
  output logic       ser_o,
  output logic [7:0] data_o,
  output logic       done_o
);

  logic [7:0] sr_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_en_i) begin
      sr_q  <= {sr_q[6:0], ser_i};
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign ser_o  = sr_q[7];
  assign data_o = sr_q;
  assign done_o = shift_en_i && (cnt_q == 3'd7);

endmodule

// File: rtl/qtcore_scan_ctrl.sv
// Host-to-qtcore scan/run sequencer: byte-wide chain exchange, bounded RUN, core reset.
// Optional rx-stream CRC-8 enabled by defining QTCORE_SCAN_CRC_EN.
module qtcore_scan_ctrl
  import qtcore_scan_ctrl_pkg::*;
#(
  parameter int CHAIN_BITS     = CHAIN_BITS_DEF,
  parameter int MIN_RUN_CYCLES = MIN_RUN_CYCLES_DEF,
  parameter int RST_CYCLES     = RST_CYCLES_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic [1:0] cmd_op_in,
  input  logic [7:0] cmd_arg_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_ready_in,
  output logic       core_scan_en_out,
  output logic       core_scan_in_out,
  input  logic       core_scan_out_in,
  output logic       core_proc_en_out,
  output logic       core_rst_out,
  output logic       busy_out,
  output logic       halted_out,
  output logic [8:0] run_cycles_out,
  output logic [7:0] rx_crc_out
);

  localparam int NBYTES = CHAIN_BITS / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e        state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [8:0]    cnt_q, cnt_d, cnt_inc;
  logic [8:0]    budget_q, budget_d;
  logic          halted_q, halted_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic          scan_en_q, proc_en_q, rst_q;
  logic          sh_load, sh_shift, sh_done, halt_seen;
  logic [7:0]    sh_data;

  qtcore_scan_ctrl_shifter u_shifter (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .load_i     (sh_load),
    .data_i     (tx_data_in),
    .shift_en_i (sh_shift),
    .ser_i      (core_scan_out_in),
    .ser_o      (core_scan_in_out),
    .data_o     (sh_data),
    .done_o     (sh_done)
  );

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    budget_d  = budget_q;
    halted_d  = halted_q;
    rcnt_d    = rcnt_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    cnt_inc   = cnt_q + 9'd1;
    halt_seen = (cnt_inc >= 9'(MIN_RUN_CYCLES)) && core_scan_out_in;
    case (state_q)
      S_IDLE: if (cmd_valid_in) begin
        case (op_e'(cmd_op_in))
          OP_XCHG: begin
            state_d = S_LOAD;
            byte_d  = '0;
          end
          OP_RUN: begin
            state_d  = S_RUN;
            cnt_d    = '0;
            budget_d = (cmd_arg_in == 8'd0) ? 9'd256 : {1'b0, cmd_arg_in};
            halted_d = 1'b0;
          end
          OP_RESET: begin
            state_d = S_RST;
            rcnt_d  = '0;
          end
          default: ;
        endcase
      end
      S_LOAD: if (tx_valid_in) begin
        sh_load = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sh_shift = 1'b1;
        if (sh_done) state_d = S_DRAIN;
      end
      S_DRAIN: if (rx_ready_in) begin
        if (byte_q == BW'(NBYTES - 1)) state_d = S_IDLE;
        else begin
          byte_d  = byte_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      // Halt is checked before the budget so a coincident halt is reported.
      S_RUN: begin
        cnt_d = cnt_inc;
        if (halt_seen || (cnt_inc == budget_q)) begin
          state_d  = S_IDLE;
          halted_d = halt_seen;
        end
      end
      S_RST: begin
        if (rcnt_q == 8'(RST_CYCLES - 1)) state_d = S_IDLE;
        else rcnt_d = rcnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      byte_q    <= '0;
      cnt_q     <= '0;
      budget_q  <= '0;
      halted_q  <= 1'b0;
      rcnt_q    <= '0;
      scan_en_q <= 1'b0;
      proc_en_q <= 1'b0;
      rst_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      budget_q  <= budget_d;
      halted_q  <= halted_d;
      rcnt_q    <= rcnt_d;
      scan_en_q <= (state_d == S_SHIFT);
      proc_en_q <= (state_d == S_RUN);
      rst_q     <= (state_d == S_RST);
    end
  end

  assign cmd_ready_out    = (state_q == S_IDLE);
  assign busy_out         = (state_q != S_IDLE);
  assign tx_ready_out     = (state_q == S_LOAD);
  assign rx_valid_out     = (state_q == S_DRAIN);
  assign rx_data_out      = sh_data;
  assign core_scan_en_out = scan_en_q;
  assign core_proc_en_out = proc_en_q;
  assign core_rst_out     = rst_q;
  assign halted_out       = halted_q;
  assign run_cycles_out   = cnt_q;

`ifdef QTCORE_SCAN_CRC_EN
  logic [7:0] crc_q;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      crc_q <= '0;
    else if (cmd_ready_out && cmd_valid_in && (cmd_op_in == OP_XCHG))
      crc_q <= '0;
    else if (sh_done)
      crc_q <= crc8_byte(crc_q, {sh_data[6:0], core_scan_out_in});
  end
  assign rx_crc_out = crc_q;
`else
  assign rx_crc_out = 8'h00;
`endif

endmodule

// File: tb/tb_qtcore_scan_ctrl.sv
// Directed bench for qtcore_scan_ctrl with a 176-bit scan chain model and a
// stub core whose halt flag rises after a programmable number of proc_en cycles.
module tb_qtcore_scan_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [1:0] cmd_op_in;
  logic [7:0] cmd_arg_in;
  logic [7:0] tx_data_in;
  logic       tx_valid_in;
  logic       tx_ready_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_ready_in;
  logic       core_scan_en_out;
  logic       core_scan_in_out;
  logic       core_scan_out_in;
  logic       core_proc_en_out;
  logic       core_rst_out;
  logic       busy_out;
  logic       halted_out;
  logic [8:0] run_cycles_out;
  logic [7:0] rx_crc_out;

  qtcore_scan_ctrl dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .cmd_valid_in     (cmd_valid_in),
    .cmd_ready_out    (cmd_ready_out),
    .cmd_op_in        (cmd_op_in),
    .cmd_arg_in       (cmd_arg_in),
    .tx_data_in       (tx_data_in),
    .tx_valid_in      (tx_valid_in),
    .tx_ready_out     (tx_ready_out),
    .rx_data_out      (rx_data_out),
    .rx_valid_out     (rx_valid_out),
    .rx_ready_in      (rx_ready_in),
    .core_scan_en_out (core_scan_en_out),
    .core_scan_in_out (core_scan_in_out),
    .core_scan_out_in (core_scan_out_in),
    .core_proc_en_out (core_proc_en_out),
    .core_rst_out     (core_rst_out),
    .busy_out         (busy_out),
    .halted_out       (halted_out),
    .run_cycles_out   (run_cycles_out),
    .rx_crc_out       (rx_crc_out)
  );

  always #5 clk_in = ~clk_in;

  // Core stub: scan chain plus proc_en counter driving the halt flag.
  logic [175:0] chain = '0;
  int pcount = 0, ecount = 0, rcount = 0, viol = 0;
  int pbase = 0, halt_at = 1000;
  logic halt;
  assign halt = ((pcount - pbase) >= halt_at);
  assign core_scan_out_in = core_scan_en_out ? chain[175] : halt;

  always @(posedge clk_in) begin
    if (core_scan_en_out) chain <= {chain[174:0], core_scan_in_out};
    if (core_scan_en_out) ecount <= ecount + 1;
    if (core_proc_en_out) pcount <= pcount + 1;
    if (core_rst_out) rcount <= rcount + 1;
    if ((core_scan_en_out && (tx_ready_out || rx_valid_out)) ||
        (core_scan_en_out && core_proc_en_out)) viol <= viol + 1;
  end

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [175:0] mkpat(input int s);
    logic [175:0] p;
    for (int i = 0; i < 22; i++) p[175-8*i -: 8] = 8'((i * 37 + s * 11 + 5) & 255);
    return p;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] arg);
    int t = 0;
    while (!cmd_ready_out && t < 400) begin @(negedge clk_in); t++; end
    if (!cmd_ready_out) chk("cmd_ready_wait", 256'(cmd_ready_out), 256'd1);
    cmd_valid_in = 1'b1; cmd_op_in = op; cmd_arg_in = arg;
    @(negedge clk_in);
    cmd_valid_in = 1'b0;
  endtask

  task automatic xchg(input logic [175:0] txv, output logic [175:0] rxv, input int gap,
                      input int sbyte, input int slen, input int abort_b, output logic [7:0] crc0);
    int t;
    rxv = '0; crc0 = '0;
    do_cmd(2'd0, 8'd0);
    for (int b = 0; b < 22; b++) begin
      t = 0;
      while (!tx_ready_out && t < 50) begin @(negedge clk_in); t++; end
      if (!tx_ready_out) begin chk("tx_ready_wait", 256'(tx_ready_out), 256'd1); return; end
      repeat (gap) @(negedge clk_in);
      tx_data_in = txv[175-8*b -: 8]; tx_valid_in = 1'b1;
      @(negedge clk_in);
      tx_valid_in = 1'b0;
      if (b == abort_b) begin repeat (4) @(negedge clk_in); return; end
      t = 0;
      while (!rx_valid_out && t < 50) begin @(negedge clk_in); t++; end
      if (!rx_valid_out) begin chk("rx_valid_wait", 256'(rx_valid_out), 256'd1); return; end
      if (b == sbyte) repeat (slen) @(negedge clk_in);
      if (b == 0) crc0 = rx_crc_out;
      rxv[175-8*b -: 8] = rx_data_out;
      rx_ready_in = 1'b1;
      @(negedge clk_in);
      rx_ready_in = 1'b0;
    end
  endtask

  task automatic run(input logic [7:0] arg, input int hat, input int exp_k, input logic exp_h);
    int p0, t;
    halt_at = hat; pbase = pcount; p0 = pcount;
    do_cmd(2'd1, arg);
    t = 0;
    while (!cmd_ready_out && t < 400) begin @(negedge clk_in); t++; end
    chk("run_done", 256'(cmd_ready_out), 256'd1);
    chk("run_cycles", 256'(run_cycles_out), 256'(exp_k));
    chk("run_halted", 256'(halted_out), 256'(exp_h));
    chk("run_proc_en_cycles", 256'(pcount - p0), 256'(exp_k));
  endtask

`ifdef QTCORE_SCAN_CRC_EN
  function automatic logic [7:0] crc_ref(input logic [175:0] v);
    logic [7:0] c = '0;
    for (int i = 175; i >= 0; i--) c = (c[7] ^ v[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction
`endif

  localparam logic [33:0] RST_VIEW = {1'b1, 33'd0};

  initial begin
    logic [175:0] rx, p1, p2, p3, p4, p5;
    logic [7:0] c0;
    int e0, v0, r0;
    rst_n_in = 1'b0; cmd_valid_in = 1'b0; cmd_op_in = '0; cmd_arg_in = '0;
    tx_data_in = '0; tx_valid_in = 1'b0; rx_ready_in = 1'b0;
    p1 = mkpat(1); p2 = mkpat(2); p3 = mkpat(3); p4 = mkpat(4); p5 = mkpat(5);
    #12;
    chk("reset_outputs", 256'({cmd_ready_out, tx_ready_out, rx_data_out, rx_valid_out,
        core_scan_en_out, core_scan_in_out, core_proc_en_out, core_rst_out, busy_out,
        halted_out, run_cycles_out, rx_crc_out}), 256'(RST_VIEW));
    @(negedge clk_in); rst_n_in = 1'b1; @(negedge clk_in);

    // Basic exchange round trip through the 176-bit chain.
    e0 = ecount;
    xchg(p1, rx, 0, -1, 0, -1, c0);
    chk("xchg1_rx_initial_chain", 256'(rx), 256'd0);
    chk("xchg1_scan_en_cycles", 256'(ecount - e0), 256'd176);
    xchg(p2, rx, 0, -1, 0, -1, c0);
    chk("xchg2_rx", 256'(rx), 256'(p1));
    chk("chain_holds_p2", 256'(chain), 256'(p2));

    // Reset during byte 3 of an exchange, then exchanges resume cleanly.
    xchg(p3, rx, 0, -1, 0, 3, c0);
    rst_n_in = 1'b0; #1;
    chk("midshift_reset_outputs", 256'({cmd_ready_out, tx_ready_out, rx_data_out, rx_valid_out,
        core_scan_en_out, core_scan_in_out, core_proc_en_out, core_rst_out, busy_out,
        halted_out, run_cycles_out, rx_crc_out}), 256'(RST_VIEW));
    @(negedge clk_in); rst_n_in = 1'b1; @(negedge clk_in);
    xchg(p3, rx, 0, -1, 0, -1, c0);
    xchg(p4, rx, 0, -1, 0, -1, c0);
    chk("post_reset_xchg_rx", 256'(rx), 256'(p3));

    // Gapped tx and 5-cycle rx stall on byte 7.
    e0 = ecount; v0 = viol;
    xchg(p5, rx, 3, 7, 5, -1, c0);
    chk("stall_xchg_rx", 256'(rx), 256'(p4));
    chk("stall_scan_en_cycles", 256'(ecount - e0), 256'd176);
    chk("stall_no_scan_en_pulses", 256'(viol - v0), 256'd0);
`ifndef QTCORE_SCAN_CRC_EN
    chk("crc_tied_zero", 256'(rx_crc_out), 256'd0);
`endif

    // RUN: budget, stale-halt window, halt, halt/budget tie, arg 0 = 256.
    run(8'd8, 1000, 8, 1'b0);
    run(8'd20, 0, 4, 1'b1);
    do_cmd(2'd3, 8'd0);
    chk("nop_idle_next_cycle", 256'({busy_out, cmd_ready_out}), 256'b01);
    chk("halted_sticky", 256'(halted_out), 256'd1);
    run(8'd20, 9, 10, 1'b1);
    run(8'd6, 5, 6, 1'b1);
    run(8'd0, 1000, 256, 1'b0);

    // RESET command pulses core reset for exactly two cycles.
    r0 = rcount;
    do_cmd(2'd2, 8'd0);
    chk("rst_busy", 256'({busy_out, core_rst_out}), 256'b11);
    repeat (4) @(negedge clk_in);
    chk("rst_cycles", 256'(rcount - r0), 256'd2);
    chk("rst_back_idle", 256'({cmd_ready_out, core_rst_out}), 256'b10);
    chk("no_overlap_total", 256'(viol), 256'd0);

`ifdef QTCORE_SCAN_CRC_EN
    xchg(176'd0, rx, 0, -1, 0, -1, c0);
    xchg({8'h01, 168'd0}, rx, 0, -1, 0, -1, c0);
    chk("crc_all_zero", 256'(rx_crc_out), 256'd0);
    xchg(176'd0, rx, 0, -1, 0, -1, c0);
    chk("crc_first_byte_01", 256'(c0), 256'h07);
    chk("crc_full_stream", 256'(rx_crc_out), 256'(crc_ref({8'h01, 168'd0})));
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", npass, ntot);
    $fatal(1, "watchdog");
  end

endmodule
